playback_sequencer: RTL and testbench



---
 rtl/playback_sequencer_pkg.sv | 23 ++
 rtl/playback_sequencer_beat_divider.sv | 32 +++
 rtl/playback_sequencer.sv | 107 ++++++++++
 tb/tb_playback_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/playback_sequencer_pkg.sv
// Shared definitions for the playback/game sequencer: state encoding and
// the beat-counter width helper.
package playback_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DEMO_PLAY  = 3'd1,
        DEMO_PAUSE = 3'd2,
        COUNTDOWN  = 3'd3,
        GAME_RUN   = 3'd4,
        GAME_DONE  = 3'd5
    } seq_state_t;

    localparam logic [1:0] COUNTDOWN_START = 2'd3;

    // Width of a counter that must reach max(a, b) - 1; never narrower than one bit.
    function automatic int beat_count_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/playback_sequencer_beat_divider.sv
// Free-running beat divider: one tick every BEAT_DIV cycles, cleared on
// demand and frozen while held so a paused song keeps its beat phase.
module beat_divider
    import playback_sequencer_pkg::*;
#(
    parameter int BEAT_DIV = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int DW = $clog2(BEAT_DIV);
    localparam logic [DW-1:0] LAST = DW'(BEAT_DIV - 1);

    logic [DW-1:0] c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            c <= '0;
        else if (clear)
            c <= '0;
        else if (!hold)
            c <= (c == LAST) ? '0 : c + DW'(1);
    end

    // A count frozen at LAST during a pause must not keep strobing.
    assign tick = (c == LAST) && !hold;

endmodule

// File: rtl/playback_sequencer.sv
// Run/stop sequencer for playback and game modes: turns button pulses into
// beat-rate enables, runs the pre-game countdown and ends the game on song_end.
module playback_sequencer
    import playback_sequencer_pkg::*;
#(
    parameter int BEAT_DIV    = 12_500_000,
    parameter int DIGIT_BEATS = 8,
    parameter int DONE_BEATS  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       mode_sel,
    input  logic       song_end,
    output logic       play,
    output logic       mode,
    output logic       game_run,
    output logic       game_step,
    output logic [1:0] countdown,
    output logic [2:0] state
);

    localparam int BW = beat_count_width(DIGIT_BEATS, DONE_BEATS);
    localparam logic [BW-1:0] DIGIT_LAST = BW'(DIGIT_BEATS - 1);
    localparam logic [BW-1:0] DONE_LAST  = BW'(DONE_BEATS - 1);

    seq_state_t    fsm;
    seq_state_t    fsm_next;
    logic [BW-1:0] beat_count;
    logic          tick;
    logic          clear;
    logic          hold;
    logic          pause_toggle;
    logic          digit_last;
    logic          done_last;

    assign digit_last = (beat_count == DIGIT_LAST);
    assign done_last  = (beat_count == DONE_LAST);

    // btn_start is checked first in every state so it beats pause and song_end.
    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:       if (btn_start) fsm_next = mode_sel ? DEMO_PLAY : COUNTDOWN;
            DEMO_PLAY:  if (btn_start) fsm_next = IDLE;
                        else if (btn_pause) fsm_next = DEMO_PAUSE;
            DEMO_PAUSE: if (btn_start) fsm_next = IDLE;
                        else if (btn_pause) fsm_next = DEMO_PLAY;
            COUNTDOWN:  if (btn_start) fsm_next = IDLE;
                        else if (tick && digit_last && countdown == 2'd1) fsm_next = GAME_RUN;
            GAME_RUN:   if (btn_start) fsm_next = IDLE;
                        else if (song_end) fsm_next = GAME_DONE;
            GAME_DONE:  if (btn_start) fsm_next = IDLE;
                        else if (tick && done_last) fsm_next = IDLE;
            default:    fsm_next = IDLE;
        endcase
    end

    // Pause/resume keeps the beat phase; every other transition restarts it.
    assign pause_toggle = (fsm == DEMO_PLAY  && fsm_next == DEMO_PAUSE) ||
                          (fsm == DEMO_PAUSE && fsm_next == DEMO_PLAY);
    assign clear = (fsm == IDLE) || ((fsm_next != fsm) && !pause_toggle);
    assign hold  = (fsm == DEMO_PAUSE);

    beat_divider #(.BEAT_DIV(BEAT_DIV)) u_divider (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .hold  (hold),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm        <= IDLE;
            mode       <= 1'b0;
            countdown  <= 2'd0;
            beat_count <= '0;
        end else begin
            fsm <= fsm_next;

            if (fsm == IDLE && btn_start)
                mode <= mode_sel;

            if (fsm_next != COUNTDOWN)
                countdown <= 2'd0;
            else if (fsm != COUNTDOWN)
                countdown <= COUNTDOWN_START;
            else if (tick && digit_last)
                countdown <= countdown - 2'd1;

            if (fsm_next != fsm)
                beat_count <= '0;
            else if (tick && fsm == COUNTDOWN)
                beat_count <= digit_last ? '0 : beat_count + BW'(1);
            else if (tick && fsm == GAME_DONE)
                beat_count <= done_last ? '0 : beat_count + BW'(1);
        end
    end

    assign play      = tick && (fsm == DEMO_PLAY);
    assign game_step = tick && (fsm == GAME_RUN);
    assign game_run  = (fsm == GAME_RUN) || (fsm == GAME_DONE);
    assign state     = fsm;

endmodule

// File: tb/tb_playback_sequencer.sv
// Scoreboard bench for playback_sequencer with BEAT_DIV=4, DIGIT_BEATS=2,
// DONE_BEATS=3; each driven cycle queues the outputs expected after its edge.
module tb_playback_sequencer;

    typedef struct packed {
        logic       play;
        logic       mode;
        logic       game_run;
        logic       game_step;
        logic [1:0] countdown;
        logic [2:0] state;
    } outs_t;

    typedef struct {
        int    due;
        string tag;
        outs_t exp;
    } sb_entry_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_pause = 1'b0;
    logic       mode_sel = 1'b0;
    logic       song_end = 1'b0;
    logic       play;
    logic       mode;
    logic       game_run;
    logic       game_step;
    logic [1:0] countdown;
    logic [2:0] state;

    outs_t     outs_now;
    sb_entry_t sb[$];
    int        cyc = 0;
    int        check_count = 0;
    int        pass_count = 0;

    playback_sequencer #(.BEAT_DIV(4), .DIGIT_BEATS(2), .DONE_BEATS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_pause (btn_pause),
        .mode_sel  (mode_sel),
        .song_end  (song_end),
        .play      (play),
        .mode      (mode),
        .game_run  (game_run),
        .game_step (game_step),
        .countdown (countdown),
        .state     (state)
    );

    always #5 clk = ~clk;

    assign outs_now = {play, mode, game_run, game_step, countdown, state};

    function automatic outs_t mk(input logic p, input logic m, input logic gr,
                                 input logic gs, input logic [1:0] cd, input logic [2:0] st);
        return {p, m, gr, gs, cd, st};
    endfunction

    task automatic checkOutput(input string tag, input logic [8:0] actual, input logic [8:0] expected);
        check_count++;
        if (actual === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s at cycle %0d: got %b expected %b (play,mode,run,step,cd,state)",
                     tag, cyc, actual, expected);
    endtask

    // One clock of stimulus; the expected outputs after this edge go on the queue.
    task automatic applyStimulus(input logic start, input logic pause, input logic msel,
                                 input logic send, input outs_t exp, input string tag);
        btn_start = start;
        btn_pause = pause;
        mode_sel  = msel;
        song_end  = send;
        sb.push_back('{cyc + 1, tag, exp});
        @(posedge clk);
        @(negedge clk);
        btn_start = 1'b0;
        btn_pause = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            sb_entry_t e;
            e = sb.pop_front();
            checkOutput(e.tag, outs_now, e.exp);
        end
    end

    // Start a game and walk the 3-2-1 countdown into GAME_RUN (edge 24).
    task automatic enterGame();
        applyStimulus(1, 0, 0, 0, mk(0, 0, 0, 0, 2'd3, 3'd3), "game_entry");
        for (int n = 1; n < 24; n++)
            applyStimulus(0, 0, 0, 0, mk(0, 0, 0, 0, 2'(3 - n / 8), 3'd3), "countdown");
        applyStimulus(0, 0, 0, 0, mk(0, 0, 1, 0, 2'd0, 3'd4), "game_start");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk);
        checkOutput("reset_state", outs_now, 9'b0);
        reset = 1'b0;
        @(negedge clk);

        // Demo run; mode_sel wiggles after start and must be ignored.
        applyStimulus(1, 0, 1, 0, mk(0, 1, 0, 0, 2'd0, 3'd1), "demo_entry");
        for (int n = 1; n <= 17; n++)
            applyStimulus(0, 0, n[0], 0, mk(n % 4 == 3, 1, 0, 0, 2'd0, 3'd1), "demo_play");

        // Pause two cycles after the strobe at edge 16, resume ten cycles later.
        applyStimulus(0, 1, 1, 0, mk(0, 1, 0, 0, 2'd0, 3'd2), "pause_enter");
        for (int n = 0; n < 10; n++)
            applyStimulus(0, 0, 1, 0, mk(0, 1, 0, 0, 2'd0, 3'd2), "paused");
        applyStimulus(0, 1, 1, 0, mk(0, 1, 0, 0, 2'd0, 3'd1), "resume");
        applyStimulus(0, 0, 1, 0, mk(1, 1, 0, 0, 2'd0, 3'd1), "resume_play");
        applyStimulus(0, 0, 1, 0, mk(0, 1, 0, 0, 2'd0, 3'd1), "after_strobe");
        applyStimulus(1, 1, 1, 0, mk(0, 1, 0, 0, 2'd0, 3'd0), "prio_demo");
        applyStimulus(0, 0, 0, 0, mk(0, 1, 0, 0, 2'd0, 3'd0), "idle_hold");

        // Full game: countdown, steps, song end, auto return to IDLE.
        enterGame();
        for (int n = 25; n <= 35; n++)
            applyStimulus(0, 0, 0, 0, mk(0, 0, 1, (n - 24) % 4 == 3, 2'd0, 3'd4), "game_step");
        applyStimulus(0, 0, 0, 1, mk(0, 0, 1, 0, 2'd0, 3'd5), "song_end");
        for (int n = 37; n <= 47; n++)
            applyStimulus(0, 0, 0, 1, mk(0, 0, 1, 0, 2'd0, 3'd5), "game_done");
        applyStimulus(0, 0, 0, 1, mk(0, 0, 0, 0, 2'd0, 3'd0), "done_idle");
        applyStimulus(0, 0, 0, 0, mk(0, 0, 0, 0, 2'd0, 3'd0), "idle_after_done");

        // Start aborts the countdown; pause inside the countdown is ignored.
        applyStimulus(1, 0, 0, 0, mk(0, 0, 0, 0, 2'd3, 3'd3), "cd_entry");
        for (int n = 1; n <= 5; n++)
            applyStimulus(0, n == 2, 0, 0, mk(0, 0, 0, 0, 2'd3, 3'd3), "cd_pause_ignored");
        applyStimulus(1, 0, 0, 0, mk(0, 0, 0, 0, 2'd0, 3'd0), "prio_countdown");

        // Start beats song_end in GAME_RUN; pause there is ignored.
        enterGame();
        applyStimulus(0, 0, 0, 0, mk(0, 0, 1, 0, 2'd0, 3'd4), "run_a");
        applyStimulus(0, 0, 0, 0, mk(0, 0, 1, 0, 2'd0, 3'd4), "run_b");
        applyStimulus(0, 1, 0, 0, mk(0, 0, 1, 1, 2'd0, 3'd4), "run_pause_ignored");
        applyStimulus(1, 0, 0, 1, mk(0, 0, 0, 0, 2'd0, 3'd0), "prio_game");

        // Asynchronous reset between edges during GAME_RUN, then a clean restart.
        enterGame();
        applyStimulus(0, 0, 0, 0, mk(0, 0, 1, 0, 2'd0, 3'd4), "run_before_reset");
        #2 reset = 1'b1;
        #1 checkOutput("reset_async", outs_now, 9'b0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1, 0, 0, 0, mk(0, 0, 0, 0, 2'd3, 3'd3), "restart");
        for (int n = 1; n <= 8; n++)
            applyStimulus(0, 0, 0, 0, mk(0, 0, 0, 0, 2'(3 - n / 8), 3'd3), "restart_cd");

        for (int n = 0; n < 5 && sb.size() > 0; n++)
            @(negedge clk);
        if (sb.size() > 0)
            checkOutput("scoreboard_drain", 9'(sb.size()), 9'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
